imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder_if.sv | 23 ++
 rtl/imm_encoder.sv | 117 +++++++++++
 tb/tb_imm_encoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder: request side carries the
// instruction template and immediate, response side carries the encoded head entry.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base;
  logic [2:0]  ExtOp;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  err;

  modport master (
    output in_valid, base, ExtOp, imm, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, base, ExtOp, imm, out_ready,
    output in_ready, out_valid, instr, err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs an immediate into an RV32 I/U/S/B/J instruction template, flags range,
// alignment and format problems, and buffers results in a 2-entry output FIFO.
module imm_encoder (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus,
  output logic [15:0]  enc_count,
  output logic [15:0]  err_count
);

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_U = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4
  } fmt_e;

  function automatic logic all_same(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] hi;
    hi = v >> lsb;
    return (hi == 32'd0) || (hi == ({32{1'b1}} >> lsb));
  endfunction

  function automatic logic [31:0] encode(input logic [31:0] b, input logic [2:0] op,
                                         input logic [31:0] im);
    case (op)
      FMT_I:   return {im[11:0], b[19:0]};
      FMT_U:   return {im[31:12], b[11:0]};
      FMT_S:   return {im[11:5], b[24:12], im[4:0], b[6:0]};
      FMT_B:   return {im[12], im[10:5], b[24:12], im[4:1], im[11], b[6:0]};
      FMT_J:   return {im[20], im[10:1], im[11], im[19:12], b[11:0]};
      default: return b;
    endcase
  endfunction

  // err[2] illegal format, err[1] misaligned, err[0] out of range.
  function automatic logic [2:0] check(input logic [2:0] op, input logic [31:0] im);
    case (op)
      FMT_I, FMT_S: return {2'b00, ~all_same(im, 11)};
      FMT_U:        return {2'b00, im[11:0] != 12'd0};
      FMT_B:        return {1'b0, im[0], ~all_same(im, 12)};
      FMT_J:        return {1'b0, im[0], ~all_same(im, 20)};
      default:      return 3'b100;
    endcase
  endfunction

  logic [1:0]  occ_q, occ_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [15:0] enc_cnt_q, enc_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] mem_instr_q [2];
  logic [2:0]  mem_err_q [2];

  logic        accept;
  logic        pop;
  logic [31:0] enc_instr;
  logic [2:0]  enc_err;

  assign enc_instr = encode(bus.base, bus.ExtOp, bus.imm);
  assign enc_err   = check(bus.ExtOp, bus.imm);

  assign bus.in_ready  = !rst && (occ_q != 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.instr     = bus.out_valid ? mem_instr_q[rd_ptr_q] : 32'd0;
  assign bus.err       = bus.out_valid ? mem_err_q[rd_ptr_q] : 3'd0;
  assign enc_count     = enc_cnt_q;
  assign err_count     = err_cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
      if (enc_cnt_q != 16'hFFFF) enc_cnt_d = enc_cnt_q + 16'd1;
      if (enc_err != 3'd0 && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      enc_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is never reset; outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_instr_q[wr_ptr_q] <= enc_instr;
      mem_err_q[wr_ptr_q]   <= enc_err;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes reference results on accept,
// a negedge monitor compares every presented head entry in order.
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  imm_encoder_if bus();

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned exp_enc = 0;
  int unsigned exp_err = 0;
  bit          mon_en = 1'b0;
  bit          rand_on = 1'b0;

  // Reference: field placement by shift/mask, range by signed magnitude bounds.
  function automatic exp_t model(input logic [31:0] b, input logic [2:0] op,
                                 input logic [31:0] im);
    exp_t   e;
    longint s;
    s = longint'($signed(im));
    e.err = 3'd0;
    case (op)
      3'd0: begin
        e.instr  = (b & 32'h000FFFFF) | ((im & 32'hFFF) << 20);
        e.err[0] = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        e.instr  = (im & 32'hFFFFF000) | (b & 32'hFFF);
        e.err[0] = (im & 32'hFFF) != 0;
      end
      3'd2: begin
        e.instr  = (b & 32'h01FFF07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
        e.err[0] = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        e.instr  = (b & 32'h01FFF07F) | (((im >> 12) & 32'h1) << 31) |
                   (((im >> 5) & 32'h3F) << 25) | (((im >> 1) & 32'hF) << 8) |
                   (((im >> 11) & 32'h1) << 7);
        e.err[0] = (s < -4096) || (s > 4095);
        e.err[1] = im[0];
      end
      3'd4: begin
        e.instr  = (b & 32'hFFF) | (((im >> 20) & 32'h1) << 31) |
                   (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20) |
                   (((im >> 12) & 32'hFF) << 12);
        e.err[0] = (s < -(64'sd1 << 20)) || (s > ((64'sd1 << 20) - 1));
        e.err[1] = im[0];
      end
      default: begin
        e.instr = b;
        e.err   = 3'b100;
      end
    endcase
    return e;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endfunction

  // Monitor: head entry must match scoreboard front; idle outputs must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", bus.instr, 32'hxxxxxxxx);
        end else begin
          chk("instr", bus.instr, sb[0].instr);
          chk("err", {29'd0, bus.err}, {29'd0, sb[0].err});
          if (bus.out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_instr", bus.instr, 32'd0);
        chk("idle_err", {29'd0, bus.err}, 32'd0);
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] b, input logic [2:0] op, input logic [31:0] im);
    int   n;
    bit   done;
    exp_t e;
    n = 0;
    done = 1'b0;
    bus.base = b;
    bus.ExtOp = op;
    bus.imm = im;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = model(b, op, im);
        sb.push_back(e);
        if (exp_enc < 32'hFFFF) exp_enc++;
        if (e.err != 3'd0 && exp_err < 32'hFFFF) exp_err++;
        done = 1'b1;
      end else if (++n > 300) begin
        total++;
        bad++;
        $display("FAIL send_timeout: actual=stalled required=accept");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", sb.size(), 0);
    cycles(1);
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    chk({tag, "_enc_count"}, {16'd0, enc_count}, exp_enc);
    chk({tag, "_err_count"}, {16'd0, err_count}, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.base = 32'd0;
    bus.ExtOp = 3'd0;
    bus.imm = 32'd0;
    bus.out_ready = 1'b1;
    cycles(1);
    @(negedge clk);
    chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors, including the worked examples.
    send(32'h00000093, 3'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("first_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("first_instr", bus.instr, 32'hFFF00093);
    chk("first_enc_count", {16'd0, enc_count}, 32'd1);
    @(posedge clk);
    #1;
    send(32'h00000063, 3'd3, 32'h00000008);
    send(32'h000000EF, 3'd4, 32'h00000800);
    send(32'h00000013, 3'd0, 32'h00000800);
    send(32'h00000063, 3'd3, 32'h00000003);
    send(32'h12345678, 3'd6, 32'hDEADBEEF);
    send(32'h00000037, 3'd1, 32'hABCDE000);
    send(32'h00000023, 3'd2, 32'hFFFFF800);
    send(32'h0000006F, 3'd4, 32'hFFF00000);
    send(32'h0000006F, 3'd4, 32'h00100000);
    drain();
    check_counts("directed");

    // Backpressure: third request stalls until the first pop.
    bus.out_ready = 1'b0;
    send(32'h00000013, 3'd0, 32'h00000001);
    send(32'h00000013, 3'd0, 32'h00000002);
    fork
      send(32'h00000013, 3'd0, 32'h00000003);
    join_none
    @(negedge clk);
    chk("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    cycles(3);
    chk("bp_still_two", sb.size(), 2);
    bus.out_ready = 1'b1;
    wait fork;
    drain();
    check_counts("backpressure");

    // Reset while two entries are buffered and a request is pending.
    bus.out_ready = 1'b0;
    send(32'h00000013, 3'd0, 32'h00000011);
    send(32'h00000013, 3'd0, 32'h00000022);
    bus.base = 32'h00000013;
    bus.ExtOp = 3'd7;
    bus.imm = 32'd0;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    exp_enc = 0;
    exp_err = 0;
    @(negedge clk);
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_counts("post_reset");
    bus.out_ready = 1'b1;

    // Random traffic with random consumer stalls.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] im;
          case ($urandom_range(0, 3))
            0: im = $urandom;
            1: im = 32'($signed(12'($urandom)));
            2: im = 32'($signed(21'($urandom)));
            default: im = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h0, 12'($urandom)};
          endcase
          send($urandom, 3'($urandom_range(0, 7)), im);
          if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #2;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check_counts("random");

    // Saturation of both counters with illegal-format requests.
    for (int i = 0; i < 65537; i++) send(32'h00000013, 3'd5, 32'd0);
    drain();
    check_counts("saturate");
    chk("sat_enc_ffff", {16'd0, enc_count}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
